bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: instruction and data requesters share one memory port and an
// 8-slot I/O window at 248..255, with per-target wait states and alternating tie-break.
module bus_arbiter #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       IREQ,
    input  logic [7:0] IA,
    input  logic       DREQ,
    input  logic [7:0] DA,
    input  logic       DWE,
    output logic [7:0] MA,
    output logic       MEN,
    output logic       MWE,
    output logic [7:0] I_O_A,
    output logic       IO_WE,
    output logic       IACK,
    output logic       DACK,
    output logic       DSRC,
    output logic       BUSY
);

    typedef enum logic [1:0] {StIdle, StImem, StDmem, StDio} state_e;

    localparam logic [2:0] MemWaitL = 3'(MEM_WAIT);
    localparam logic [2:0] IoWaitL  = 3'(IO_WAIT);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_q, last_d;   // 0 = instruction served last, 1 = data
    logic [7:0] ma_q, ma_d;
    logic       men_q, men_d;
    logic       mwe_q, mwe_d;
    logic [7:0] ioa_q, ioa_d;
    logic       iowe_q, iowe_d;
    logic       take_data;

    // Data wins when it is the only request, or on a tie when instruction went last.
    assign take_data = DREQ && (!IREQ || !last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            last_q  <= 1'b0;
            ma_q    <= 8'h00;
            men_q   <= 1'b0;
            mwe_q   <= 1'b0;
            ioa_q   <= 8'h00;
            iowe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ma_q    <= ma_d;
            men_q   <= men_d;
            mwe_q   <= mwe_d;
            ioa_q   <= ioa_d;
            iowe_q  <= iowe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ma_d    = ma_q;
        men_d   = men_q;
        mwe_d   = mwe_q;
        ioa_d   = ioa_q;
        iowe_d  = iowe_q;
        unique case (state_q)
            StIdle: begin
                if (IREQ || DREQ) begin
                    if (take_data) begin
                        last_d = 1'b1;
                        if (DA >= 8'd248) begin
                            state_d = StDio;
                            ioa_d   = 8'b1 << DA[2:0];
                            iowe_d  = DWE;
                            men_d   = 1'b0;
                            cnt_d   = IoWaitL;
                        end else begin
                            state_d = StDmem;
                            ma_d    = DA;
                            men_d   = 1'b1;
                            mwe_d   = DWE;
                            cnt_d   = MemWaitL;
                        end
                    end else begin
                        last_d  = 1'b0;
                        state_d = StImem;
                        ma_d    = IA;
                        men_d   = 1'b1;
                        mwe_d   = 1'b0;
                        cnt_d   = MemWaitL;
                    end
                end
            end
            StImem, StDmem, StDio: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    // Ack cycle: strobes drop with the return to idle, MA is kept.
                    state_d = StIdle;
                    men_d   = 1'b0;
                    mwe_d   = 1'b0;
                    ioa_d   = 8'h00;
                    iowe_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign MA    = ma_q;
    assign MEN   = men_q;
    assign MWE   = mwe_q;
    assign I_O_A = ioa_q;
    assign IO_WE = iowe_q;
    assign IACK  = (state_q == StImem) && (cnt_q == 3'd0);
    assign DACK  = ((state_q == StDmem) || (state_q == StDio)) && (cnt_q == 3'd0);
    assign DSRC  = (state_q == StDio);
    assign BUSY  = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected accesses are queued when requests are driven
// and compared when the matching ACK appears; a second instance covers zero-wait alternation.
module tb_bus_arbiter;

    localparam int MW = 1;
    localparam int IW = 2;

    typedef struct {
        logic       is_data;
        logic       dsrc;
        logic [7:0] ma;
        logic       men;
        logic       mwe;
        logic [7:0] ioa;
        logic       iowe;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
    logic [7:0] ia = 8'h00, da = 8'h00;
    logic [7:0] ma, ioa;
    logic       men, mwe, iowe, iack, dack, dsrc, busy;

    logic       ireq2 = 1'b0, dreq2 = 1'b0, dwe2 = 1'b0;
    logic [7:0] ia2 = 8'h00, da2 = 8'h00;
    logic [7:0] ma2, ioa2;
    logic       men2, mwe2, iowe2, iack2, dack2, dsrc2, busy2;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sbq[$];
    bit   exp2[$];
    logic [7:0] ma_model = 8'h00;
    bit   last_model = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .IREQ(ireq), .IA(ia), .DREQ(dreq), .DA(da), .DWE(dwe),
        .MA(ma), .MEN(men), .MWE(mwe), .I_O_A(ioa), .IO_WE(iowe),
        .IACK(iack), .DACK(dack), .DSRC(dsrc), .BUSY(busy)
    );

    bus_arbiter #(.MEM_WAIT(0), .IO_WAIT(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .IREQ(ireq2), .IA(ia2), .DREQ(dreq2), .DA(da2), .DWE(dwe2),
        .MA(ma2), .MEN(men2), .MWE(mwe2), .I_O_A(ioa2), .IO_WE(iowe2),
        .IACK(iack2), .DACK(dack2), .DSRC(dsrc2), .BUSY(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic push_i(input logic [7:0] ia_v);
        exp_t e;
        ma_model = ia_v;
        last_model = 1'b0;
        e = '{is_data: 1'b0, dsrc: 1'b0, ma: ia_v, men: 1'b1, mwe: 1'b0,
              ioa: 8'h00, iowe: 1'b0, lat: MW + 1};
        sbq.push_back(e);
    endtask

    task automatic push_d(input logic [7:0] da_v, input logic we_v);
        exp_t e;
        logic [7:0] sel;
        bit io;
        io = (da_v >= 8'd248);
        sel = 8'h01;
        if (!io) ma_model = da_v;
        last_model = 1'b1;
        e = '{is_data: 1'b1, dsrc: io, ma: ma_model, men: !io, mwe: !io && we_v,
              ioa: io ? (sel << da_v[2:0]) : 8'h00, iowe: io && we_v,
              lat: (io ? IW : MW) + 1};
        sbq.push_back(e);
    endtask

    task automatic push_pair(input bit di, input logic [7:0] ia_v, input bit dd,
                             input logic [7:0] da_v, input logic we_v);
        if (di && dd) begin
            if (!last_model) begin
                push_d(da_v, we_v);
                push_i(ia_v);
            end else begin
                push_i(ia_v);
                push_d(da_v, we_v);
            end
        end else if (di) begin
            push_i(ia_v);
        end else if (dd) begin
            push_d(da_v, we_v);
        end
    endtask

    // mode 0: hold inputs; 1: scramble address/DWE after grant; 2: withdraw REQ after grant
    task automatic wait_acks(input int n, input int mode);
        int got = 0;
        int cyc = 0;
        bit first = 1'b1;
        while (got < n && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (busy && first && mode != 0) begin
                first = 1'b0;
                if (mode == 1) begin
                    ia  = 8'($urandom);
                    da  = 8'($urandom_range(0, 200));
                    dwe = ~dwe;
                end else begin
                    ireq = 1'b0;
                    dreq = 1'b0;
                end
            end
            if (iack) begin ireq = 1'b0; got++; end
            if (dack) begin dreq = 1'b0; got++; end
        end
        if (got < n) begin
            check("ack_timeout", 32'(got), 32'(n));
            sbq.delete();
        end
    endtask

    task automatic issue(input bit di, input logic [7:0] ia_v, input bit dd,
                         input logic [7:0] da_v, input logic we_v, input int mode);
        @(negedge clk);
        ireq = di; ia = ia_v; dreq = dd; da = da_v; dwe = we_v;
        push_pair(di, ia_v, dd, da_v, we_v);
        wait_acks(int'(di) + int'(dd), mode);
    endtask

    // Monitor: invariants every cycle, scoreboard compare on each ACK.
    initial begin
        int   busy_cnt = 0;
        bit   prev_ack = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                prev_ack = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                else busy_cnt = 0;
                check("ack_excl", 32'(iack & dack), 32'(0));
                check("men_ioa_excl", 32'(men && (ioa != 8'h00)), 32'(0));
                check("ioa_onehot0", 32'($countones(ioa) <= 1), 32'(1));
                if (prev_ack)
                    check("idle_after_ack", {23'(0), busy, men, mwe, ioa, iowe}, 32'(0));
                if (iack || dack) begin
                    if (sbq.size() == 0) begin
                        check("spurious_ack", 32'(1), 32'(0));
                    end else begin
                        e = sbq.pop_front();
                        check("ack_port", 32'(dack), 32'(e.is_data));
                        check("ma", 32'(ma), 32'(e.ma));
                        check("men", 32'(men), 32'(e.men));
                        check("mwe", 32'(mwe), 32'(e.mwe));
                        check("i_o_a", 32'(ioa), 32'(e.ioa));
                        check("io_we", 32'(iowe), 32'(e.iowe));
                        check("dsrc", 32'(dsrc), 32'(e.dsrc));
                        check("latency", 32'(busy_cnt), 32'(e.lat));
                    end
                end
                prev_ack = iack || dack;
            end
        end
    end

    initial begin
        int cyc;
        int last_ack;
        #1;
        check("reset_outputs", {16'(0), ma, men, mwe, iowe, iack, dack, dsrc, busy, 1'b0},
              32'(0));
        check("reset_ioa", 32'(ioa), 32'(0));

        // Tie straight out of reset: data first, instruction on the next idle cycle.
        ireq = 1'b1; ia = 8'h55; dreq = 1'b1; da = 8'h10; dwe = 1'b1;
        push_pair(1'b1, 8'h55, 1'b1, 8'h10, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_edge_grant", 32'(busy), 32'(1));
        check("first_grant_data", 32'(mwe), 32'(1));
        wait_acks(2, 0);

        issue(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 0);
        issue(1'b0, 8'h00, 1'b1, 8'd250, 1'b0, 0);
        for (int i = 248; i <= 255; i++)
            issue(1'b0, 8'h00, 1'b1, 8'(i), 1'(i), (i == 251) ? 1 : 0);
        issue(1'b0, 8'h00, 1'b1, 8'd247, 1'b1, 0);
        issue(1'b1, 8'h9A, 1'b0, 8'h00, 1'b0, 1);
        issue(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 2);
        issue(1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 2);
        issue(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 0);
        issue(1'b1, 8'h66, 1'b1, 8'd253, 1'b1, 0);

        // Reset in the middle of an I/O wait state must kill the access without an ACK.
        @(negedge clk);
        dreq = 1'b1; da = 8'd252; dwe = 1'b1;
        @(negedge clk);
        check("dio_busy", 32'(dsrc), 32'(1));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {16'(0), ma, men, mwe, iowe, iack, dack, dsrc, busy, 1'b0}, 32'(0));
        check("async_reset_ioa", 32'(ioa), 32'(0));
        dreq = 1'b0;
        ma_model = 8'h00;
        last_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", 32'(busy), 32'(0));
        issue(1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 0);
        issue(1'b1, 8'h77, 1'b1, 8'h78, 1'b0, 0);

        // Zero memory wait, both requests held: D, I, D, I ... every second cycle.
        @(negedge clk);
        ireq2 = 1'b1; dreq2 = 1'b1; ia2 = 8'h40; da2 = 8'h20; dwe2 = 1'b0;
        for (int k = 0; k < 6; k++) exp2.push_back(k % 2 == 0);
        cyc = 0;
        last_ack = -1;
        while (exp2.size() > 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            check("alt_ack_excl", 32'(iack2 & dack2), 32'(0));
            if (iack2 || dack2) begin
                check("alt_port", 32'(dack2), 32'(exp2.pop_front()));
                if (last_ack >= 0) check("ack_gap", 32'(cyc - last_ack), 32'(2));
                last_ack = cyc;
            end
        end
        check("alt_done", 32'(exp2.size()), 32'(0));
        ireq2 = 1'b0; dreq2 = 1'b0;
        repeat (2) @(negedge clk);
        check("alt_idle", {24'(0), men2, mwe2, iowe2, dsrc2, busy2, 3'(0)}, 32'(0));
        check("alt_idle_ioa", 32'(ioa2), 32'(0));
        check("alt_ma_hold", 32'(ma2), 32'(8'h40));

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
